psx_pad_emulator: RTL
=====================

Name: psx_pad_emulator

Overview:
- PPB-side protocol engine for an emulated digital Playstation pad, with optional analog mode.
- Sits directly downstream of psx_device_port.
- Consumes PPB_command/PPB_command_strobe.
- Supplies PPB_reply and PPB_ack_strobe for each byte of a poll packet.
- Reports button data from a 16-bit pressed-high input as the pad's active-low button bytes.

Parameters:
PAD_ADDRESS, 8'h01, first command byte this device answers to
POLL_COMMAND, 8'h42, second command byte that starts a poll
DIGITAL_ID, 8'h41, ID byte returned in digital mode
ANALOG_ID, 8'h73, ID byte returned in analog mode (used only with PSX_PAD_ANALOG_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
PPB_packet_reset  input  1  high = abandon packet; synchronous return to start state
PPB_command  input  8  received command byte
PPB_command_strobe  input  1  one-cycle pulse, PPB_command valid
PPB_reply_ready  input  1  one-cycle pulse, PPB_reply has just been latched by the port
PPB_reply  output  8  reply byte for the next byte slot
PPB_ack_strobe  output  1  one-cycle pulse acknowledging the current command byte
buttons  input  16  button state, 1 = pressed; bit0 = Select ... bit15 = Square
poll_done  output  1  one-cycle pulse when the final data byte's reply is latched
analog_mode  input  1  analog mode select (PSX_PAD_ANALOG_EN only)
axes  input  32  {LY,LX,RY,RX}, 8 bits each (PSX_PAD_ANALOG_EN only)

Behaviour:
- Reset and PPB_packet_reset (reset async, packet reset sync; equal effect):
  - state = S_ADDR, PPB_reply = 8'hFF, PPB_ack_strobe = 0, poll_done = 0, snapshot cleared.
  - PPB_packet_reset has priority over a same-cycle PPB_command_strobe.
- All decisions are made on the cycle PPB_command_strobe is high. In the next cycle:
  - PPB_reply is updated for the following byte.
  - PPB_ack_strobe pulses if the byte is accepted.
  - Latency is exactly 1 clk, well inside the port's ACK window.
- PPB_reply changes only in that cycle or on packet reset. Between strobes it is held stable.
- State transitions (each on PPB_command_strobe):
  - S_ADDR: cmd == PAD_ADDRESS -> ack, reply = ID, go S_CMD. Otherwise -> no ack, reply 8'hFF, go S_IGNORE.
  - S_CMD: cmd == POLL_COMMAND -> ack, reply 8'h5A, latch buttons (and axes) into snapshot, go S_TAG. Otherwise -> no ack, reply 8'hFF, go S_IGNORE.
  - S_TAG: command ignored; ack, reply = ~snap[7:0], go S_BTN0.
  - S_BTN0: ack, reply = ~snap[15:8], go S_BTN1.
  - S_BTN1, digital mode: no ack (last byte), reply 8'hFF, go S_DONE.
- Snapshot is taken once per packet, so both button bytes are coherent.
- S_IGNORE and S_DONE: every further byte -> no ack, reply 8'hFF. Only a packet reset leaves these states.
- poll_done pulses 1 cycle after PPB_reply_ready while in the final-data-byte state:
  - digital: S_BTN1;
  - analog: S_AX3.
- Extra bytes beyond the packet are tolerated: no ack, 8'hFF, no error.
- A PPB_reply_ready without a preceding command strobe has no effect except the poll_done rule.

Optional Feature:
PSX_PAD_ANALOG_EN
- Defined:
  - analog_mode and axes ports exist.
  - ID = ANALOG_ID when analog_mode is sampled high at the S_ADDR decision; that choice is held for the whole packet.
  - In analog mode, S_BTN1 acks and continues through S_AX0..S_AX3, replying snap RX, RY, LX, LY in turn.
  - S_AX0..S_AX2 ack; S_AX3 does not ack and goes to S_DONE.
- Not defined:
  - ports absent, ID always DIGITAL_ID, S_AX states not built.

Decomposition:
- Package psx_pad_pkg:
  - state enum;
  - constants REPLY_IDLE = 8'hFF, REPLY_TAG = 8'h5A;
  - default address/command/ID values;
  - button bit index constants.
- Single module: no sub-module is natural. The reply mux is a case on state.

Test Plan:
- Digital poll: buttons = 16'h0009; bytes 01,42,00,00,00.
  - replies FF,41,5A,F6,FF;
  - acks after bytes 1-4 only;
  - poll_done once.
- Wrong address: first byte 8'h81.
  - no ack on any byte;
  - all replies FF;
  - state S_IGNORE until PPB_packet_reset.
- Button change mid-packet: buttons change from 16'h0000 to 16'hFFFF after byte 2.
  - replies still FF,FF (snapshot of 16'h0000 inverted).
- Packet reset after byte 2:
  - PPB_reply returns to FF next cycle;
  - the following clean poll succeeds.
- Same-cycle PPB_packet_reset and PPB_command_strobe:
  - no ack;
  - state S_ADDR.
- Analog (macro on, analog_mode = 1, axes = 32'h11223344):
  - replies FF,73,5A,btn,btn,44,33,22,11;
  - 8 acks, none on the last byte.

Source files
------------

// File: rtl/psx_pad_pkg.sv
// Shared types and constants for the PlayStation pad emulator.
// Optional analog mode is enabled by defining PSX_PAD_ANALOG_EN.
package psx_pad_pkg;

  typedef enum logic [3:0] {
    S_ADDR   = 4'd0,
    S_CMD    = 4'd1,
    S_TAG    = 4'd2,
    S_BTN0   = 4'd3,
    S_BTN1   = 4'd4,
    S_AX0    = 4'd5,
    S_AX1    = 4'd6,
    S_AX2    = 4'd7,
    S_AX3    = 4'd8,
    S_IGNORE = 4'd9,
    S_DONE   = 4'd10
  } pad_state_e;

  localparam logic [7:0] REPLY_IDLE = 8'hFF;
  localparam logic [7:0] REPLY_TAG  = 8'h5A;

  localparam logic [7:0] DEF_PAD_ADDRESS  = 8'h01;
  localparam logic [7:0] DEF_POLL_COMMAND = 8'h42;
  localparam logic [7:0] DEF_DIGITAL_ID   = 8'h41;
  localparam logic [7:0] DEF_ANALOG_ID    = 8'h73;

  // Bit positions in the pressed-high buttons vector.
  localparam int BTN_SELECT   = 0;
  localparam int BTN_L3       = 1;
  localparam int BTN_R3       = 2;
  localparam int BTN_START    = 3;
  localparam int BTN_UP       = 4;
  localparam int BTN_RIGHT    = 5;
  localparam int BTN_DOWN     = 6;
  localparam int BTN_LEFT     = 7;
  localparam int BTN_L2       = 8;
  localparam int BTN_R2       = 9;
  localparam int BTN_L1       = 10;
  localparam int BTN_R1       = 11;
  localparam int BTN_TRIANGLE = 12;
  localparam int BTN_CIRCLE   = 13;
  localparam int BTN_CROSS    = 14;
  localparam int BTN_SQUARE   = 15;

endpackage

// File: rtl/psx_pad_emulator_if.sv
// Byte-level link between psx_device_port (master) and the pad protocol engine (slave).
interface psx_pad_emulator_if;
  logic       PPB_packet_reset;
  logic [7:0] PPB_command;
  logic       PPB_command_strobe;
  logic       PPB_reply_ready;
  logic [7:0] PPB_reply;
  logic       PPB_ack_strobe;

  modport master (
    output PPB_packet_reset,
    output PPB_command,
    output PPB_command_strobe,
    output PPB_reply_ready,
    input  PPB_reply,
    input  PPB_ack_strobe
  );

  modport slave (
    input  PPB_packet_reset,
    input  PPB_command,
    input  PPB_command_strobe,
    input  PPB_reply_ready,
    output PPB_reply,
    output PPB_ack_strobe
  );
endinterface

// File: rtl/psx_pad_emulator.sv
// Protocol engine for an emulated PlayStation pad. Answers poll packets byte by
// byte, one clock after each command strobe, with active-low button bytes.
// Define PSX_PAD_ANALOG_EN to add analog mode (ID 0x73 plus four axis bytes).
module psx_pad_emulator
  import psx_pad_pkg::*;
#(
  parameter logic [7:0] PAD_ADDRESS  = DEF_PAD_ADDRESS,
  parameter logic [7:0] POLL_COMMAND = DEF_POLL_COMMAND,
`ifdef PSX_PAD_ANALOG_EN
  parameter logic [7:0] ANALOG_ID    = DEF_ANALOG_ID,
`endif
  parameter logic [7:0] DIGITAL_ID   = DEF_DIGITAL_ID
) (
  input  logic                 clk,
  input  logic                 reset,
  psx_pad_emulator_if.slave    ppb,
  input  logic [15:0]          buttons,
`ifdef PSX_PAD_ANALOG_EN
  input  logic                 analog_mode,
  input  logic [31:0]          axes,
`endif
  output logic                 poll_done
);

  pad_state_e  state_q, state_d;
  logic [7:0]  reply_q, reply_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic [15:0] snap_btn_q, snap_btn_d;
  logic        final_byte;
`ifdef PSX_PAD_ANALOG_EN
  logic [31:0] snap_ax_q, snap_ax_d;
  logic        ana_q, ana_d;
`endif

  // Identify the state whose reply is the last data byte of the packet.
  always_comb begin
`ifdef PSX_PAD_ANALOG_EN
    final_byte = ((state_q == S_BTN1) && !ana_q) || (state_q == S_AX3);
`else
    final_byte = (state_q == S_BTN1);
`endif
  end

  // Next-state, reply and strobe decisions, taken only on a command strobe.
  always_comb begin
    state_d    = state_q;
    reply_d    = reply_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    snap_btn_d = snap_btn_q;
`ifdef PSX_PAD_ANALOG_EN
    snap_ax_d  = snap_ax_q;
    ana_d      = ana_q;
`endif
    if (ppb.PPB_packet_reset) begin
      // Packet reset wins over any same-cycle strobe.
      state_d    = S_ADDR;
      reply_d    = REPLY_IDLE;
      snap_btn_d = '0;
`ifdef PSX_PAD_ANALOG_EN
      snap_ax_d  = '0;
      ana_d      = 1'b0;
`endif
    end else begin
      done_d = ppb.PPB_reply_ready && final_byte;
      if (ppb.PPB_command_strobe) begin
        case (state_q)
          S_ADDR: begin
            if (ppb.PPB_command == PAD_ADDRESS) begin
              ack_d   = 1'b1;
              state_d = S_CMD;
`ifdef PSX_PAD_ANALOG_EN
              ana_d   = analog_mode;
              reply_d = analog_mode ? ANALOG_ID : DIGITAL_ID;
`else
              reply_d = DIGITAL_ID;
`endif
            end else begin
              reply_d = REPLY_IDLE;
              state_d = S_IGNORE;
            end
          end
          S_CMD: begin
            if (ppb.PPB_command == POLL_COMMAND) begin
              ack_d      = 1'b1;
              reply_d    = REPLY_TAG;
              snap_btn_d = buttons;
`ifdef PSX_PAD_ANALOG_EN
              snap_ax_d  = axes;
`endif
              state_d    = S_TAG;
            end else begin
              reply_d = REPLY_IDLE;
              state_d = S_IGNORE;
            end
          end
          S_TAG: begin
            ack_d   = 1'b1;
            reply_d = ~snap_btn_q[7:0];
            state_d = S_BTN0;
          end
          S_BTN0: begin
            ack_d   = 1'b1;
            reply_d = ~snap_btn_q[15:8];
            state_d = S_BTN1;
          end
          S_BTN1: begin
`ifdef PSX_PAD_ANALOG_EN
            if (ana_q) begin
              ack_d   = 1'b1;
              reply_d = snap_ax_q[7:0];
              state_d = S_AX0;
            end else begin
              reply_d = REPLY_IDLE;
              state_d = S_DONE;
            end
`else
            reply_d = REPLY_IDLE;
            state_d = S_DONE;
`endif
          end
`ifdef PSX_PAD_ANALOG_EN
          S_AX0: begin
            ack_d   = 1'b1;
            reply_d = snap_ax_q[15:8];
            state_d = S_AX1;
          end
          S_AX1: begin
            ack_d   = 1'b1;
            reply_d = snap_ax_q[23:16];
            state_d = S_AX2;
          end
          S_AX2: begin
            ack_d   = 1'b1;
            reply_d = snap_ax_q[31:24];
            state_d = S_AX3;
          end
          S_AX3: begin
            reply_d = REPLY_IDLE;
            state_d = S_DONE;
          end
`endif
          S_IGNORE, S_DONE: begin
            reply_d = REPLY_IDLE;
          end
          default: begin
            reply_d = REPLY_IDLE;
            state_d = S_IGNORE;
          end
        endcase
      end
    end
  end

  // Register state, outputs and the per-packet snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_ADDR;
      reply_q    <= REPLY_IDLE;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      snap_btn_q <= '0;
`ifdef PSX_PAD_ANALOG_EN
      snap_ax_q  <= '0;
      ana_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      reply_q    <= reply_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      snap_btn_q <= snap_btn_d;
`ifdef PSX_PAD_ANALOG_EN
      snap_ax_q  <= snap_ax_d;
      ana_q      <= ana_d;
`endif
    end
  end

  assign ppb.PPB_reply      = reply_q;
  assign ppb.PPB_ack_strobe = ack_q;
  assign poll_done          = done_q;

endmodule
